craps_round_ctrl: RTL and testbench
===================================

// Module: craps_round_ctrl
// PURPOSE
//  Sequences one complete craps round around the free-running dice counters.
//  - Gates the counters on roll_en while the roll button is held, and latches both dice on release.
//  - Applies come-out and point rules, then holds win/lose until a new game is requested.
//  - Sits between the board button/switch inputs and the counters block; its outputs drive the
//    7-segment decode and the win/lose LEDs.
// PARAMETERS
//  SYNC_STAGES   2   flops in the roll_btn synchronizer (>=2)
//  MIN_HOLD      4   clk cycles roll_btn_s must stay high for the roll to count (1..255)
//  CNT_W         8   width of the saturating roll counter
// PORTS
//  clk          in   1      system clock; everything is on its rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  roll_btn     in   1      raw asynchronous roll button, high = pressed
//  new_game     in   1      synchronous pulse: abandon/clear the round
//  dice1_in     in   3      live die-1 value from counters, legal 1..6
//  dice2_in     in   3      live die-2 value from counters, legal 1..6
//  roll_en      out  1      counter enable, high only in ROLL
//  dice1_q      out  3      latched die-1 value
//  dice2_q      out  3      latched die-2 value
//  sum_q        out  4      dice1_q + dice2_q, zero-extended, range 2..12
//  point_q      out  4      established point, 0 = none
//  point_valid  out  1      a point is established
//  win          out  1      round won; held until new_game
//  lose         out  1      round lost; held until new_game
//  roll_cnt     out  CNT_W  accepted rolls this round; saturates at all-ones
//  err          out  1      sticky: an illegal die value (0 or 7) was captured
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, sync chain 0, hold_cnt 0.
//  roll_btn_s: SYNC_STAGES-flop synchronized version of roll_btn; rise/fall are edges on roll_btn_s.
//  States:
//  - IDLE -> ROLL on rise.
//  - ROLL: roll_en=1, hold_cnt counts (saturating). On fall:
//    - hold_cnt >= MIN_HOLD: go to CAPTURE.
//    - otherwise: discard and return to ret_state (IDLE or POINT). roll_cnt and dice are unchanged.
//  - CAPTURE (1 cycle): roll_en=0. Latch dice1_q/dice2_q/sum_q from the inputs and increment roll_cnt.
//    - Either die is 0 or 7: set err, leave sum_q/point/win/lose untouched, go to ret_state.
//  - EVAL (1 cycle), uses the registered sum_q:
//    - No point (come-out roll): 7 or 11 -> WIN; 2, 3 or 12 -> LOSE; else point_q<=sum_q,
//      point_valid<=1, go to POINT.
//    - Point set: sum_q==point_q -> WIN; sum_q==7 -> LOSE; else POINT.
//  - POINT -> ROLL on rise.
//  - WIN / LOSE: terminal. win or lose is high. Rises are ignored; only new_game leaves.
//  Latency: first cycle roll_btn_s is low -> CAPTURE; dice_q valid one cycle later;
//    win/lose/point update one cycle after that (2 clk from the fall sample).
//  new_game: from any state, next cycle goes to IDLE with dice_q, sum_q, point_q, point_valid, win,
//    lose, roll_cnt and err all 0. It has priority over a simultaneous rise/fall. During ROLL it
//    aborts the roll and drops roll_en immediately.
//  Button held through new_game: no roll starts until a fresh rise.
//  win and lose are never high together; point_valid=0 whenever point_q=0.
//  sum_q width: 3b+3b zero-extended to 4b, no overflow possible for legal dice.
//  rst_n low mid-round: immediate async return to reset values.
// STRUCTURE
//  dice_pkg: state enum (IDLE, ROLL, CAPTURE, EVAL, POINT, WIN, LOSE), SUM_W=4, DIE_W=3,
//    localparams for the natural sums 7, 11 and craps sums 2, 3, 12.
//  Sub-module btn_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//  The FSM and datapath registers live in this module.
// TESTING
//  1 Come-out: press 10 cycles, dice 3+4 at release -> sum_q=7, win=1 two cycles after fall, roll_cnt=1.
//  2 Craps: dice 1+1 -> lose=1, point_valid=0. A further press is ignored: roll_en stays 0.
//  3 Point: 2+4 -> point_q=6, POINT. Then 5+2 -> lose=1. Repeat with 3+3 -> win=1, roll_cnt=2.
//  4 Short press: hold 2 cycles (MIN_HOLD=4) -> no capture, roll_cnt unchanged, state returns to IDLE/POINT.
//  5 new_game asserted in the same cycle as fall in ROLL -> IDLE, all outputs 0, no capture.
//  6 dice1_in=7 at capture -> err=1, sum_q unchanged, returns to ret_state. Then rst_n low
//    mid-ROLL -> roll_en=0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/craps_round_ctrl_pkg.sv
// Shared types and constants for the craps round controller.
//   state_t        : round sequencer states
//   DIE_W / SUM_W  : die value width and zero-extended sum width
//   SUM_* consts   : naturals (7, 11) and craps (2, 3, 12) for the come-out roll
//   die_illegal()  : true for the two encodings a 3-bit die can hold but never show
package craps_round_ctrl_pkg;

  localparam int DIE_W = 3;
  localparam int SUM_W = 4;

  localparam logic [SUM_W-1:0] SUM_NATURAL7  = 4'd7;
  localparam logic [SUM_W-1:0] SUM_NATURAL11 = 4'd11;
  localparam logic [SUM_W-1:0] SUM_CRAPS2    = 4'd2;
  localparam logic [SUM_W-1:0] SUM_CRAPS3    = 4'd3;
  localparam logic [SUM_W-1:0] SUM_CRAPS12   = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROLL,
    ST_CAPTURE,
    ST_EVAL,
    ST_POINT,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic logic die_illegal(input logic [DIE_W-1:0] die);
    return (die == 3'd0) || (die == 3'd7);
  endfunction

endpackage

// File: rtl/craps_round_ctrl_if.sv
// Bundle of the board-facing and display-facing signals of the round controller.
//   i_roll_btn, i_new_game         : button / switch inputs
//   i_dice1, i_dice2               : live values from the dice counters
//   o_roll_en                      : counter enable
//   o_dice1_q, o_dice2_q, o_sum_q  : latched roll for the 7-segment decode
//   o_point_q, o_point_valid       : established point
//   o_win, o_lose, o_roll_cnt, o_err : round result, roll count, sticky error
// master = board/counters side, slave = controller.
interface craps_round_ctrl_if #(
  parameter int CNT_W = 8
);
  import craps_round_ctrl_pkg::*;

  logic                 i_roll_btn;
  logic                 i_new_game;
  logic [DIE_W-1:0]     i_dice1;
  logic [DIE_W-1:0]     i_dice2;
  logic                 o_roll_en;
  logic [DIE_W-1:0]     o_dice1_q;
  logic [DIE_W-1:0]     o_dice2_q;
  logic [SUM_W-1:0]     o_sum_q;
  logic [SUM_W-1:0]     o_point_q;
  logic                 o_point_valid;
  logic                 o_win;
  logic                 o_lose;
  logic [CNT_W-1:0]     o_roll_cnt;
  logic                 o_err;

  modport master (
    output i_roll_btn, i_new_game, i_dice1, i_dice2,
    input  o_roll_en, o_dice1_q, o_dice2_q, o_sum_q, o_point_q, o_point_valid,
           o_win, o_lose, o_roll_cnt, o_err
  );

  modport slave (
    input  i_roll_btn, i_new_game, i_dice1, i_dice2,
    output o_roll_en, o_dice1_q, o_dice2_q, o_sum_q, o_point_q, o_point_valid,
           o_win, o_lose, o_roll_cnt, o_err
  );

endinterface

// File: rtl/craps_round_ctrl_btn_sync_edge.sv
// Synchronizes the raw roll button into the clk domain and flags its edges.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw asynchronous button
//   o_btn_s    : synchronized level
//   o_rise     : one-cycle pulse, first cycle o_btn_s is high
//   o_fall     : one-cycle pulse, first cycle o_btn_s is low
module craps_round_ctrl_btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_btn_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift chain plus one delayed copy; reset to 0 so no edge is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_btn_s = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_btn_s & ~r_prev;
  assign o_fall  = ~o_btn_s & r_prev;

endmodule

// File: rtl/craps_round_ctrl.sv
// Sequences one craps round: enables the dice counters while the roll button
// is held, latches the dice on release, applies come-out and point rules and
// holds win/lose until new_game.
//   clk, rst_n : clock, async active-low reset
//   bus        : craps_round_ctrl_if.slave (buttons, live dice, latched results)
module craps_round_ctrl
  import craps_round_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  craps_round_ctrl_if.slave     bus
);

  localparam int HOLD_W = 8;

  state_t             r_state;
  state_t             w_next_state;
  state_t             w_ret_state;
  logic               w_btn_s, w_rise, w_fall;
  logic               w_roll_en, w_start_roll, w_capture;
  logic               w_set_win, w_set_lose, w_set_point;
  logic [SUM_W-1:0]   w_sum;
  logic               w_bad_dice;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [DIE_W-1:0]   r_dice1_q, r_dice2_q;
  logic [SUM_W-1:0]   r_sum_q, r_point_q;
  logic               r_point_valid, r_win, r_lose, r_err;
  logic [CNT_W-1:0]   r_roll_cnt;

  craps_round_ctrl_btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.i_roll_btn),
    .o_btn_s(w_btn_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_sum      = {1'b0, bus.i_dice1} + {1'b0, bus.i_dice2};
  assign w_bad_dice = die_illegal(bus.i_dice1) || die_illegal(bus.i_dice2);
  // A point only exists in POINT-phase states, so it tells us where to go back to.
  assign w_ret_state = r_point_valid ? ST_POINT : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and per-cycle strobes; new_game overrides everything, including roll_en.
  always_comb begin
    w_next_state = r_state;
    w_roll_en    = 1'b0;
    w_start_roll = 1'b0;
    w_capture    = 1'b0;
    w_set_win    = 1'b0;
    w_set_lose   = 1'b0;
    w_set_point  = 1'b0;
    if (bus.i_new_game) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_POINT: begin
          if (w_rise) begin
            w_start_roll = 1'b1;
            w_next_state = ST_ROLL;
          end
        end
        ST_ROLL: begin
          w_roll_en = 1'b1;
          if (w_fall)
            w_next_state = (r_hold_cnt >= HOLD_W'(MIN_HOLD)) ? ST_CAPTURE : w_ret_state;
        end
        ST_CAPTURE: begin
          w_capture    = 1'b1;
          w_next_state = w_bad_dice ? w_ret_state : ST_EVAL;
        end
        ST_EVAL: begin
          if (!r_point_valid) begin
            if (r_sum_q == SUM_NATURAL7 || r_sum_q == SUM_NATURAL11) begin
              w_set_win    = 1'b1;
              w_next_state = ST_WIN;
            end else if (r_sum_q == SUM_CRAPS2 || r_sum_q == SUM_CRAPS3 ||
                         r_sum_q == SUM_CRAPS12) begin
              w_set_lose   = 1'b1;
              w_next_state = ST_LOSE;
            end else begin
              w_set_point  = 1'b1;
              w_next_state = ST_POINT;
            end
          end else if (r_sum_q == r_point_q) begin
            w_set_win    = 1'b1;
            w_next_state = ST_WIN;
          end else if (r_sum_q == SUM_NATURAL7) begin
            w_set_lose   = 1'b1;
            w_next_state = ST_LOSE;
          end else begin
            w_next_state = ST_POINT;
          end
        end
        ST_WIN, ST_LOSE: w_next_state = r_state;
        default:         w_next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath registers. hold_cnt starts at 1 on the rise cycle so that it equals
  // the number of cycles roll_btn_s has been high when the fall is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt    <= '0;
      r_dice1_q     <= '0;
      r_dice2_q     <= '0;
      r_sum_q       <= '0;
      r_point_q     <= '0;
      r_point_valid <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_roll_cnt    <= '0;
      r_err         <= 1'b0;
    end else if (bus.i_new_game) begin
      r_hold_cnt    <= '0;
      r_dice1_q     <= '0;
      r_dice2_q     <= '0;
      r_sum_q       <= '0;
      r_point_q     <= '0;
      r_point_valid <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_roll_cnt    <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_start_roll)
        r_hold_cnt <= HOLD_W'(1);
      else if (r_state == ST_ROLL && w_btn_s && r_hold_cnt != '1)
        r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_capture) begin
        r_dice1_q <= bus.i_dice1;
        r_dice2_q <= bus.i_dice2;
        if (r_roll_cnt != '1)
          r_roll_cnt <= r_roll_cnt + 1'b1;
        // An illegal die still shows on the display but never reaches the rules.
        if (w_bad_dice) r_err   <= 1'b1;
        else            r_sum_q <= w_sum;
      end
      if (w_set_win)  r_win  <= 1'b1;
      if (w_set_lose) r_lose <= 1'b1;
      if (w_set_point) begin
        r_point_q     <= r_sum_q;
        r_point_valid <= 1'b1;
      end
    end
  end

  assign bus.o_roll_en     = w_roll_en;
  assign bus.o_dice1_q     = r_dice1_q;
  assign bus.o_dice2_q     = r_dice2_q;
  assign bus.o_sum_q       = r_sum_q;
  assign bus.o_point_q     = r_point_q;
  assign bus.o_point_valid = r_point_valid;
  assign bus.o_win         = r_win;
  assign bus.o_lose        = r_lose;
  assign bus.o_roll_cnt    = r_roll_cnt;
  assign bus.o_err         = r_err;

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Directed bench for craps_round_ctrl: come-out win/craps, point win/lose,
// short press rejection, new_game abort, illegal die and async reset.
module tb_craps_round_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  craps_round_ctrl_if #(.CNT_W(8)) bus ();

  craps_round_ctrl #(
    .SYNC_STAGES(2),
    .MIN_HOLD   (4),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold the button for 'hold' edges with the dice fixed, release, then wait 'settle' edges.
  task automatic applyStimulus(input logic [2:0] d1, input logic [2:0] d2,
                               input int hold, input int settle);
    bus.i_dice1    = d1;
    bus.i_dice2    = d2;
    bus.i_roll_btn = 1'b1;
    tick(hold);
    bus.i_roll_btn = 1'b0;
    tick(settle);
  endtask

  task automatic newGame();
    bus.i_new_game = 1'b1;
    tick(1);
    bus.i_new_game = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n          = 1'b0;
    bus.i_roll_btn = 1'b0;
    bus.i_new_game = 1'b0;
    bus.i_dice1    = 3'd0;
    bus.i_dice2    = 3'd0;
    tick(3);

    // Reset state
    checkOutput("rst_roll_en", bus.o_roll_en, 0);
    checkOutput("rst_sum", bus.o_sum_q, 0);
    checkOutput("rst_point_valid", bus.o_point_valid, 0);
    checkOutput("rst_win_lose", {bus.o_win, bus.o_lose}, 0);
    checkOutput("rst_roll_cnt", bus.o_roll_cnt, 0);
    checkOutput("rst_err", bus.o_err, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: come-out natural 3+4, exact latency from release
    bus.i_dice1    = 3'd3;
    bus.i_dice2    = 3'd4;
    bus.i_roll_btn = 1'b1;
    tick(5);
    checkOutput("t1_roll_en_held", bus.o_roll_en, 1);
    tick(5);
    bus.i_roll_btn = 1'b0;
    tick(4);
    checkOutput("t1_dice1", bus.o_dice1_q, 3);
    checkOutput("t1_dice2", bus.o_dice2_q, 4);
    checkOutput("t1_sum", bus.o_sum_q, 7);
    checkOutput("t1_win_early", bus.o_win, 0);
    tick(1);
    checkOutput("t1_win", bus.o_win, 1);
    checkOutput("t1_lose", bus.o_lose, 0);
    checkOutput("t1_roll_cnt", bus.o_roll_cnt, 1);
    checkOutput("t1_roll_en_after", bus.o_roll_en, 0);
    // Press in WIN is ignored
    bus.i_dice1    = 3'd5;
    bus.i_dice2    = 3'd5;
    bus.i_roll_btn = 1'b1;
    tick(5);
    checkOutput("t1_win_press_roll_en", bus.o_roll_en, 0);
    tick(5);
    bus.i_roll_btn = 1'b0;
    tick(6);
    checkOutput("t1_win_press_cnt", bus.o_roll_cnt, 1);
    checkOutput("t1_win_press_dice1", bus.o_dice1_q, 3);
    newGame();
    checkOutput("t1_ng_win", bus.o_win, 0);
    checkOutput("t1_ng_cnt", bus.o_roll_cnt, 0);
    checkOutput("t1_ng_sum", bus.o_sum_q, 0);

    // 2: come-out craps 1+1
    applyStimulus(3'd1, 3'd1, 10, 6);
    checkOutput("t2_lose", bus.o_lose, 1);
    checkOutput("t2_win", bus.o_win, 0);
    checkOutput("t2_point_valid", bus.o_point_valid, 0);
    checkOutput("t2_sum", bus.o_sum_q, 2);
    bus.i_roll_btn = 1'b1;
    tick(5);
    checkOutput("t2_lose_press_roll_en", bus.o_roll_en, 0);
    bus.i_roll_btn = 1'b0;
    tick(3);
    newGame();

    // 3: point 6, then seven-out; then point 6 made
    applyStimulus(3'd2, 3'd4, 10, 6);
    checkOutput("t3_point", bus.o_point_q, 6);
    checkOutput("t3_point_valid", bus.o_point_valid, 1);
    checkOutput("t3_no_result", {bus.o_win, bus.o_lose}, 0);
    applyStimulus(3'd5, 3'd2, 10, 6);
    checkOutput("t3_seven_out_lose", bus.o_lose, 1);
    checkOutput("t3_seven_out_win", bus.o_win, 0);
    checkOutput("t3_seven_out_cnt", bus.o_roll_cnt, 2);
    newGame();
    applyStimulus(3'd2, 3'd4, 10, 6);
    applyStimulus(3'd3, 3'd3, 10, 6);
    checkOutput("t3_made_win", bus.o_win, 1);
    checkOutput("t3_made_lose", bus.o_lose, 0);
    checkOutput("t3_made_cnt", bus.o_roll_cnt, 2);

    // 4: short presses from IDLE and from POINT
    newGame();
    applyStimulus(3'd6, 3'd6, 2, 6);
    checkOutput("t4_idle_short_cnt", bus.o_roll_cnt, 0);
    checkOutput("t4_idle_short_dice1", bus.o_dice1_q, 0);
    checkOutput("t4_idle_short_lose", bus.o_lose, 0);
    applyStimulus(3'd2, 3'd4, 10, 6);
    checkOutput("t4_point_cnt", bus.o_roll_cnt, 1);
    applyStimulus(3'd6, 3'd6, 2, 6);
    checkOutput("t4_point_short_cnt", bus.o_roll_cnt, 1);
    checkOutput("t4_point_short_dice1", bus.o_dice1_q, 2);
    checkOutput("t4_point_short_sum", bus.o_sum_q, 6);
    applyStimulus(3'd3, 3'd3, 10, 6);
    checkOutput("t4_point_resume_win", bus.o_win, 1);

    // 5: new_game on the fall cycle aborts the roll
    newGame();
    applyStimulus(3'd2, 3'd4, 10, 6);
    checkOutput("t5_point_before", bus.o_point_q, 6);
    bus.i_dice1    = 3'd3;
    bus.i_dice2    = 3'd4;
    bus.i_roll_btn = 1'b1;
    tick(10);
    bus.i_roll_btn = 1'b0;
    tick(2);
    checkOutput("t5_roll_en_fall_cycle", bus.o_roll_en, 1);
    bus.i_new_game = 1'b1;
    #1;
    checkOutput("t5_roll_en_dropped", bus.o_roll_en, 0);
    tick(1);
    bus.i_new_game = 1'b0;
    checkOutput("t5_point_clr", bus.o_point_q, 0);
    checkOutput("t5_point_valid_clr", bus.o_point_valid, 0);
    checkOutput("t5_cnt_clr", bus.o_roll_cnt, 0);
    tick(6);
    checkOutput("t5_no_capture_cnt", bus.o_roll_cnt, 0);
    checkOutput("t5_no_capture_dice1", bus.o_dice1_q, 0);
    checkOutput("t5_no_capture_result", {bus.o_win, bus.o_lose}, 0);
    // Button held through new_game must not restart a roll
    bus.i_roll_btn = 1'b1;
    tick(5);
    checkOutput("t5_held_roll_en", bus.o_roll_en, 1);
    newGame();
    tick(4);
    checkOutput("t5_held_after_ng", bus.o_roll_en, 0);
    bus.i_roll_btn = 1'b0;
    tick(6);
    checkOutput("t5_held_cnt", bus.o_roll_cnt, 0);

    // 6: illegal die, then async reset mid-ROLL
    applyStimulus(3'd2, 3'd4, 10, 6);
    checkOutput("t6_point", bus.o_point_q, 6);
    applyStimulus(3'd7, 3'd3, 10, 6);
    checkOutput("t6_err", bus.o_err, 1);
    checkOutput("t6_dice1", bus.o_dice1_q, 7);
    checkOutput("t6_dice2", bus.o_dice2_q, 3);
    checkOutput("t6_sum_kept", bus.o_sum_q, 6);
    checkOutput("t6_cnt", bus.o_roll_cnt, 2);
    checkOutput("t6_point_kept", bus.o_point_valid, 1);
    checkOutput("t6_no_result", {bus.o_win, bus.o_lose}, 0);
    bus.i_dice1    = 3'd1;
    bus.i_dice2    = 3'd2;
    bus.i_roll_btn = 1'b1;
    tick(5);
    checkOutput("t6_back_in_point_roll_en", bus.o_roll_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_roll_en", bus.o_roll_en, 0);
    checkOutput("t6_rst_err", bus.o_err, 0);
    checkOutput("t6_rst_cnt", bus.o_roll_cnt, 0);
    checkOutput("t6_rst_point", bus.o_point_q, 0);
    checkOutput("t6_rst_dice1", bus.o_dice1_q, 0);
    bus.i_roll_btn = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
